biquad_filter: RTL and testbench
================================

# biquad_filter

Second-order IIR (biquad) section in Direct Form I, fixed-point, one sample per clock. Coefficients are compile-time parameters. Used in the synth filter chain between the oscillator/mixer stage and the output stage. It accepts a signed sample every cycle and produces a registered filtered sample.

## Interface
Parameters:
- INOUT_WIDTH, 16: din/dout width, signed two's complement.
- INOUT_DECIMAL_WIDTH, 14: fractional bits of din/dout. The default format is Q2.14, so 0x4000 = +1.0 and 0xC000 = −1.0.
- COEF_WIDTH, 24: coefficient width, signed.
- COEF_DECIMAL_WIDTH, 22: coefficient fractional bits. The default format is Q2.22, so 0x400000 = +1.0.
- INTERNAL_WIDTH, 24: width of state registers (x/y history).
- INTERNAL_DECIMAL_WIDTH, 22: fractional bits of the internal format.
- b0, b1, b2, a1, a2, all 0: coefficients, COEF_WIDTH bits, signed.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- din, input, INOUT_WIDTH: input sample, sampled every rising edge.
- dout, output, INOUT_WIDTH: filtered sample, registered.

Legal configurations require both of the following. Elaboration fails otherwise.
- INTERNAL_DECIMAL_WIDTH ≥ INOUT_DECIMAL_WIDTH.
- INTERNAL_WIDTH − INTERNAL_DECIMAL_WIDTH ≥ INOUT_WIDTH − INOUT_DECIMAL_WIDTH.

## Operation
- Transfer function: y[n] = b0·x[n] + b1·x[n−1] + b2·x[n−2] − a1·y[n−1] − a2·y[n−2]. The feedback terms are subtracted.
- Input conversion: x[n] = sign-extend(din) << (INTERNAL_DECIMAL_WIDTH − INOUT_DECIMAL_WIDTH), in internal format.
- Products: each product is an exact signed COEF_WIDTH+INTERNAL_WIDTH product.
- Accumulation: the five products are summed exactly in an accumulator of COEF_WIDTH+INTERNAL_WIDTH+3 bits.
- Scaling to internal format: accumulator >>> COEF_DECIMAL_WIDTH, arithmetic shift, truncation toward −∞, no rounding.
- Narrowing to INTERNAL_WIDTH: performed per the Configuration section (saturate or wrap). The narrowed value is y[n], which is both the fed-back state and the output source.
- Output conversion: dout = y[n] >>> (INTERNAL_DECIMAL_WIDTH − INOUT_DECIMAL_WIDTH), then narrowed to INOUT_WIDTH with the same saturate/wrap rule.
- State: four INTERNAL_WIDTH registers x1, x2, y1, y2.
- Zero coefficients contribute nothing. No special-casing is required.

## Timing
- Every rising edge: x1←x[n], x2←x1, y1←y[n], y2←y1, dout←conv(y[n]). The path from din to the y[n] computation is combinational.
- Latency: a sample on din at edge k appears on dout immediately after edge k (one register stage). There are no valid/ready signals and the block accepts a sample every cycle.
- Reset (asynchronous, while high): x1, x2, y1, y2 and dout are forced to 0 immediately. The first edge after deassertion processes din normally.
- Reset mid-stream discards all history. It produces no transient beyond the zero-state response.

## Configuration
- BIQUAD_SATURATE_EN defined: every narrowing step (internal y[n] and dout) clamps to the most positive or most negative representable value of the target width.
- BIQUAD_SATURATE_EN undefined: every narrowing step keeps the low bits (two's-complement wrap).
- All other behaviour is identical in both builds.

## Structure
- Shared package biquad_pkg holds:
  - the accumulator-width localparam derivation;
  - a narrowing function (saturate or wrap, selected by the macro);
  - the shift constant INTERNAL_DECIMAL_WIDTH − INOUT_DECIMAL_WIDTH.
- One sub-module, biquad_sat_resize: a parameterized signed narrowing stage (input width, output width). It is instantiated for the y[n] narrowing and for the dout narrowing.
- The multiply-accumulate and state registers stay in biquad_filter.

## Test plan
All scenarios use default widths unless noted.
- Reset: assert reset asynchronously mid-cycle → dout = 0x0000 immediately; x/y history cleared. After release with din = 0, dout stays 0x0000.
- Differentiator, step: b0 = 0x400000, b1 = 0xC00000, others 0; after reset, din steps 0x0000→0xC000 → dout = 0xC000 on the first edge, then 0x0000 on every later edge.
- Identity with delay: b0 = 0x400000 only; din sequence 0x1000, 0xE000, 0x3FFF → dout follows the same values one edge after each is applied.
- Feedback: b0 = 0x400000, a1 = 0xE00000 (−0.5); impulse din = 0x4000 for one cycle then 0 → dout = 0x4000, 0x2000, 0x1000, 0x0800, …
- Overflow: differentiator coefficients; din 0x6000 (+1.5) then 0xA000 (−1.5) → dout 0x8000 with BIQUAD_SATURATE_EN, 0x4000 without.
- Format conversion: INOUT_DECIMAL_WIDTH = 12 with b0 = 1.0; din = 0x0800 → dout = 0x0800; negative din truncates toward −∞.

Source files
------------

// File: rtl/biquad_pkg.sv
// biquad_pkg
// Shared definitions for the biquad filter slice:
//   accWidth    - accumulator width for five exact coef x state products
//   fmtShift    - bit shift between the I/O format and the internal format
//   narrowValue - signed narrowing to a target width
// Build option: BIQUAD_SATURATE_EN selects clamping narrowing. When it is
// undefined, narrowing keeps the low bits (two's-complement wrap).
package biquad_pkg;

  // Widest value narrowValue can carry; callers sign-extend into this width.
  localparam int NARROW_MAX_W = 128;

  // Three guard bits are enough for the sum of five full-width products.
  function automatic int accWidth(input int coefW, input int intW);
    return coefW + intW + 3;
  endfunction

  function automatic int fmtShift(input int intDec, input int ioDec);
    return intDec - ioDec;
  endfunction

  // Narrows a sign-extended value to outW bits and returns the result
  // sign-extended back to NARROW_MAX_W bits.
  function automatic logic signed [NARROW_MAX_W-1:0] narrowValue(
    input logic signed [NARROW_MAX_W-1:0] v,
    input int                             outW
  );
`ifdef BIQUAD_SATURATE_EN
    logic signed [NARROW_MAX_W-1:0] one;
    logic signed [NARROW_MAX_W-1:0] maxV;
    logic signed [NARROW_MAX_W-1:0] minV;
    one  = NARROW_MAX_W'(1);
    maxV = (one <<< (outW - 1)) - one;
    minV = ~maxV;
    if (v > maxV) return maxV;
    if (v < minV) return minV;
    return v;
`else
    int drop;
    drop = NARROW_MAX_W - outW;
    // The left shift discards the high bits; the arithmetic right shift
    // re-extends the new sign bit.
    return (v <<< drop) >>> drop;
`endif
  endfunction

endpackage

// File: rtl/biquad_sat_resize.sv
// biquad_sat_resize
// Parameterized signed narrowing stage (saturate or wrap; see biquad_pkg).
// Build option: BIQUAD_SATURATE_EN (through biquad_pkg::narrowValue).
// Ports:
//   din_i  - signed input, IN_W bits
//   dout_o - signed narrowed output, OUT_W bits
import biquad_pkg::*;

module biquad_sat_resize #(
  parameter int IN_W  = 51,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);

  if (IN_W > NARROW_MAX_W || OUT_W > IN_W || OUT_W < 2) begin : g_badWidths
    $error("biquad_sat_resize: unsupported widths IN_W=%0d OUT_W=%0d", IN_W, OUT_W);
  end

  assign dout_o = OUT_W'(narrowValue(NARROW_MAX_W'(din_i), OUT_W));

endmodule

// File: rtl/biquad_filter.sv
// biquad_filter
// Second-order IIR section in Direct Form I. The section takes one sample
// every clock, and its coefficients are fixed when the design is built.
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
// Build option: BIQUAD_SATURATE_EN selects clamping for both narrowing steps.
// When the option is undefined, both steps wrap.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high; clears history and dout
//   din   - signed input sample, sampled every rising edge
//   dout  - signed filtered sample, registered
import biquad_pkg::*;

module biquad_filter #(
  parameter int INOUT_WIDTH            = 16,
  parameter int INOUT_DECIMAL_WIDTH    = 14,
  parameter int COEF_WIDTH             = 24,
  parameter int COEF_DECIMAL_WIDTH     = 22,
  parameter int INTERNAL_WIDTH         = 24,
  parameter int INTERNAL_DECIMAL_WIDTH = 22,
  parameter logic signed [COEF_WIDTH-1:0] b0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] b1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] b2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] a1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] a2 = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [INOUT_WIDTH-1:0] din,
  output logic signed [INOUT_WIDTH-1:0] dout
);

  localparam int SHIFT  = fmtShift(INTERNAL_DECIMAL_WIDTH, INOUT_DECIMAL_WIDTH);
  localparam int PROD_W = COEF_WIDTH + INTERNAL_WIDTH;
  localparam int ACC_W  = accWidth(COEF_WIDTH, INTERNAL_WIDTH);

  // The internal format must hold every I/O value exactly.
  if (INTERNAL_DECIMAL_WIDTH < INOUT_DECIMAL_WIDTH) begin : g_badFraction
    $error("biquad_filter: INTERNAL_DECIMAL_WIDTH must be >= INOUT_DECIMAL_WIDTH");
  end
  if (INTERNAL_WIDTH - INTERNAL_DECIMAL_WIDTH < INOUT_WIDTH - INOUT_DECIMAL_WIDTH) begin : g_badInteger
    $error("biquad_filter: internal integer bits must be >= I/O integer bits");
  end

  logic signed [INTERNAL_WIDTH-1:0] xn;
  logic signed [INTERNAL_WIDTH-1:0] yn;
  logic signed [INTERNAL_WIDTH-1:0] yOutScaled;
  logic signed [INTERNAL_WIDTH-1:0] x1_q, x2_q, y1_q, y2_q;
  logic signed [INTERNAL_WIDTH-1:0] x1_d, x2_d, y1_d, y2_d;
  logic signed [INOUT_WIDTH-1:0]    dout_q, dout_d;
  logic signed [PROD_W-1:0]         pB0, pB1, pB2, pA1, pA2;
  logic signed [ACC_W-1:0]          accSum;
  logic signed [ACC_W-1:0]          accScaled;

  // Move the input into the internal format. The legality checks above
  // guarantee that the shift cannot overflow.
  assign xn = INTERNAL_WIDTH'(din) <<< SHIFT;

  // Both operands are widened to the product width before multiplying, so
  // each product is exact.
  assign pB0 = PROD_W'(b0) * PROD_W'(xn);
  assign pB1 = PROD_W'(b1) * PROD_W'(x1_q);
  assign pB2 = PROD_W'(b2) * PROD_W'(x2_q);
  assign pA1 = PROD_W'(a1) * PROD_W'(y1_q);
  assign pA2 = PROD_W'(a2) * PROD_W'(y2_q);

  // Exact sum with the feedback terms subtracted. The result is then scaled
  // back to the internal format by flooring (arithmetic shift, no rounding).
  assign accSum    = ACC_W'(pB0) + ACC_W'(pB1) + ACC_W'(pB2)
                   - ACC_W'(pA1) - ACC_W'(pA2);
  assign accScaled = accSum >>> COEF_DECIMAL_WIDTH;

  biquad_sat_resize #(
    .IN_W  (ACC_W),
    .OUT_W (INTERNAL_WIDTH)
  ) u_yResize (
    .din_i  (accScaled),
    .dout_o (yn)
  );

  assign yOutScaled = yn >>> SHIFT;

  biquad_sat_resize #(
    .IN_W  (INTERNAL_WIDTH),
    .OUT_W (INOUT_WIDTH)
  ) u_outResize (
    .din_i  (yOutScaled),
    .dout_o (dout_d)
  );

  always_comb begin
    x1_d = xn;
    x2_d = x1_q;
    y1_d = yn;
    y2_d = y1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1_q   <= '0;
      x2_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      dout_q <= '0;
    end else begin
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      y1_q   <= y1_d;
      y2_q   <= y2_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_biquad_filter.sv
// tb_biquad_filter
// Drives several biquad_filter configurations from one shared input stream.
// Outputs are compared with directed constants and with an arithmetic model
// of the difference equation.
// Build option: BIQUAD_SATURATE_EN (the bench follows whichever build is used).
module tb_biquad_filter;

  localparam int NI = 6;

  localparam logic signed [23:0] K_ZERO  = 24'h000000;
  localparam logic signed [23:0] K_ONE   = 24'h400000;
  localparam logic signed [23:0] K_MONE  = 24'hC00000;
  localparam logic signed [23:0] K_HALF  = 24'h200000;
  localparam logic signed [23:0] K_MHALF = 24'hE00000;
  localparam logic signed [23:0] K_QTR   = 24'h100000;
  localparam logic signed [23:0] K_A1    = 24'hD9999A;
  localparam logic signed [23:0] K_A2    = 24'h0CCCCD;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic [15:0] doutArr [NI];

  int checkCount;
  int failCount;

  // Reference model state, in plain integers of the internal format.
  longint cb0 [NI], cb1 [NI], cb2 [NI], ca1 [NI], ca2 [NI];
  int     shiftOf [NI];
  longint mx1 [NI], mx2 [NI], my1 [NI], my2 [NI], mexp [NI];

  // 0: differentiator, 1: identity, 2: one-pole feedback, 3: Q4.12 identity,
  // 4: low-pass, 5: Q4.12 half gain
  biquad_filter #(.b0(K_ONE), .b1(K_MONE)) u_diff (
    .clk(clk), .reset(reset), .din(din), .dout(doutArr[0]));

  biquad_filter #(.b0(K_ONE)) u_ident (
    .clk(clk), .reset(reset), .din(din), .dout(doutArr[1]));

  biquad_filter #(.b0(K_ONE), .a1(K_MHALF)) u_fback (
    .clk(clk), .reset(reset), .din(din), .dout(doutArr[2]));

  biquad_filter #(.INOUT_DECIMAL_WIDTH(12), .INTERNAL_DECIMAL_WIDTH(20),
                  .b0(K_ONE)) u_fmt (
    .clk(clk), .reset(reset), .din(din), .dout(doutArr[3]));

  biquad_filter #(.b0(K_QTR), .b1(K_HALF), .b2(K_QTR), .a1(K_A1), .a2(K_A2)) u_lowpass (
    .clk(clk), .reset(reset), .din(din), .dout(doutArr[4]));

  biquad_filter #(.INOUT_DECIMAL_WIDTH(12), .INTERNAL_DECIMAL_WIDTH(20),
                  .b0(K_HALF)) u_fmtHalf (
    .clk(clk), .reset(reset), .din(din), .dout(doutArr[5]));

  always #5 clk = ~clk;

  // Integer division rounded toward minus infinity.
  function automatic longint floorDiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Fits a value into w signed bits, using the same rule as the build.
  function automatic longint narrowTo(input longint v, input int w);
    longint lim;
    longint span;
    longint m;
    lim  = longint'(1) << (w - 1);
    span = lim * 2;
`ifdef BIQUAD_SATURATE_EN
    m = v;
    if (v >= lim) m = lim - 1;
    if (v < -lim) m = -lim;
`else
    m = v % span;
    if (m < 0) m = m + span;
    if (m >= lim) m = m - span;
`endif
    return m;
  endfunction

  task automatic resetModels();
    for (int k = 0; k < NI; k++) begin
      mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; mexp[k] = 0;
    end
  endtask

  task automatic modelStep(input int k, input logic [15:0] dv);
    longint x, acc, y;
    x   = longint'($signed(dv)) * (longint'(1) << shiftOf[k]);
    acc = cb0[k] * x + cb1[k] * mx1[k] + cb2[k] * mx2[k]
        - ca1[k] * my1[k] - ca2[k] * my2[k];
    y   = narrowTo(floorDiv(acc, longint'(1) << 22), 24);
    mexp[k] = narrowTo(floorDiv(y, longint'(1) << shiftOf[k]), 16);
    mx2[k] = mx1[k];
    mx1[k] = x;
    my2[k] = my1[k];
    my1[k] = y;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one sample, clocks it in, and checks every instance against
  // the model just after the edge.
  task automatic applyStimulus(input logic [15:0] v);
    din = v;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      modelStep(k, v);
      checkOutput($sformatf("model%0d", k), doutArr[k], 16'(mexp[k]));
    end
  endtask

  // Asserts reset between edges, checks the asynchronous clear, and releases
  // reset on a falling edge.
  task automatic pulseReset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    resetModels();
    for (int k = 0; k < NI; k++)
      checkOutput($sformatf("%s_async%0d", tag, k), doutArr[k], 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    din = 16'h0000;
    checkCount = 0;
    failCount = 0;
    cb0 = '{longint'(K_ONE), longint'(K_ONE), longint'(K_ONE), longint'(K_ONE), longint'(K_QTR), longint'(K_HALF)};
    cb1 = '{longint'(K_MONE), longint'(K_ZERO), longint'(K_ZERO), longint'(K_ZERO), longint'(K_HALF), longint'(K_ZERO)};
    cb2 = '{longint'(K_ZERO), longint'(K_ZERO), longint'(K_ZERO), longint'(K_ZERO), longint'(K_QTR), longint'(K_ZERO)};
    ca1 = '{longint'(K_ZERO), longint'(K_ZERO), longint'(K_MHALF), longint'(K_ZERO), longint'(K_A1), longint'(K_ZERO)};
    ca2 = '{longint'(K_ZERO), longint'(K_ZERO), longint'(K_ZERO), longint'(K_ZERO), longint'(K_A2), longint'(K_ZERO)};
    shiftOf = '{8, 8, 8, 8, 8, 8};
    resetModels();

    #12;
    for (int k = 0; k < NI; k++)
      checkOutput($sformatf("resetState%0d", k), doutArr[k], 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Differentiator: a step gives one nonzero output, then zero.
    applyStimulus(16'h0000);
    checkOutput("diffIdle", doutArr[0], 16'h0000);
    applyStimulus(16'hC000);
    checkOutput("diffStepEdge", doutArr[0], 16'hC000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'hC000);
      checkOutput("diffStepHold", doutArr[0], 16'h0000);
    end

    // Identity: the output follows the input one edge later.
    applyStimulus(16'h1000);
    checkOutput("ident1000", doutArr[1], 16'h1000);
    applyStimulus(16'hE000);
    checkOutput("identE000", doutArr[1], 16'hE000);
    applyStimulus(16'h3FFF);
    checkOutput("ident3FFF", doutArr[1], 16'h3FFF);

    // Mid-stream reset drops the history; zero input must then give zero.
    pulseReset("midReset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0000);
      checkOutput("postResetIdent", doutArr[1], 16'h0000);
      checkOutput("postResetLowpass", doutArr[4], 16'h0000);
    end

    // Feedback with a1 = -0.5: the impulse response halves on every edge.
    applyStimulus(16'h4000);
    checkOutput("fbImpulse0", doutArr[2], 16'h4000);
    applyStimulus(16'h0000);
    checkOutput("fbImpulse1", doutArr[2], 16'h2000);
    applyStimulus(16'h0000);
    checkOutput("fbImpulse2", doutArr[2], 16'h1000);
    applyStimulus(16'h0000);
    checkOutput("fbImpulse3", doutArr[2], 16'h0800);
    applyStimulus(16'h0000);
    checkOutput("fbImpulse4", doutArr[2], 16'h0400);

    // Overflow: +1.5 then -1.5 through the differentiator gives -3.0.
    pulseReset("preOverflow");
    applyStimulus(16'h6000);
    checkOutput("ovfFirst", doutArr[0], 16'h6000);
    applyStimulus(16'hA000);
`ifdef BIQUAD_SATURATE_EN
    checkOutput("ovfSecond", doutArr[0], 16'h8000);
`else
    checkOutput("ovfSecond", doutArr[0], 16'h4000);
`endif

    // Q4.12 I/O: identity passes the value; half gain floors negatives.
    applyStimulus(16'h0800);
    checkOutput("fmtIdent0800", doutArr[3], 16'h0800);
    checkOutput("fmtHalf0800", doutArr[5], 16'h0400);
    applyStimulus(16'hFFFF);
    checkOutput("fmtIdentFFFF", doutArr[3], 16'hFFFF);
    checkOutput("fmtHalfFloorNeg", doutArr[5], 16'hFFFF);
    applyStimulus(16'h0001);
    checkOutput("fmtHalfFloorPos", doutArr[5], 16'h0000);

    // Random samples, checked against the model on every edge.
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0)
        applyStimulus(16'($urandom));
      else
        applyStimulus(16'($urandom_range(16'h3000, 0)) - 16'h1800);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
